// File: rtl/nn_accel_ctrl.sv
// Command front-end and operand sequencer for the 4x4 MAC array.
// Define NN_CTRL_IRQ_EN to build the completion interrupt and the CTRL/STATUS IE bit.
module nn_accel_ctrl #(
  parameter int ACC_LAT = 1,
  parameter int ITER_W  = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [4:0]   cmd_addr,
  input  logic [31:0]  cmd_wdata,
  output logic         rsp_valid,
  output logic [31:0]  rsp_rdata,
  output logic         busy,
  output logic         irq,
  output logic         acc_clear,
  output logic [127:0] acc_in_flat,
  output logic [511:0] acc_w_flat,
  input  logic [127:0] acc_out_flat
);

  localparam logic [4:0] ADDR_W_END  = 5'd20;
  localparam logic [4:0] ADDR_CTRL   = 5'd20;
  localparam logic [4:0] ADDR_STATUS = 5'd21;
  localparam logic [4:0] ADDR_ITER   = 5'd22;
  localparam int DRAIN_W = (ACC_LAT > 1) ? $clog2(ACC_LAT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    CAPTURE
  } state_t;

  state_t state, state_next;

  logic [31:0]        in_vec [4];
  logic [31:0]        w_mat  [16];
  logic [31:0]        res    [4];
  logic [ITER_W-1:0]  iter_reg;
  logic [ITER_W-1:0]  run_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               done;
  logic               err;
  logic               ie;

  logic        wr_en, rd_en, ctrl_wr, start_req, clr_req, data_wr, start_go;
  logic [31:0] rd_mux;
  logic [31:0] rd_hold;
  logic        rd_pend;

  assign cmd_ready = 1'b1;
  assign wr_en     = cmd_valid & cmd_write;
  assign rd_en     = cmd_valid & ~cmd_write;
  assign ctrl_wr   = wr_en && (cmd_addr == ADDR_CTRL);
  assign start_req = ctrl_wr & cmd_wdata[0];
  assign clr_req   = ctrl_wr & cmd_wdata[1];
  assign data_wr   = wr_en && ((cmd_addr < ADDR_W_END) || (cmd_addr == ADDR_ITER));
  assign busy      = (state != IDLE);
  assign start_go  = start_req & ~busy;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_req) state_next = CLEAR;
      CLEAR: begin
        if (iter_reg != '0)  state_next = RUN;
        else if (ACC_LAT > 0) state_next = DRAIN;
        else                  state_next = CAPTURE;
      end
      RUN: begin
        if (run_cnt == ITER_W'(1)) state_next = (ACC_LAT > 0) ? DRAIN : CAPTURE;
      end
      DRAIN:   if (drain_cnt == DRAIN_W'(1)) state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // acc_clear is registered from the next state so it is high exactly for the CLEAR cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc_clear <= 1'b0;
      run_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      acc_clear <= (state_next == CLEAR);
      if (state == CLEAR)    run_cnt <= iter_reg;
      else if (state == RUN) run_cnt <= run_cnt - ITER_W'(1);
      if ((state_next == DRAIN) && (state != DRAIN)) drain_cnt <= DRAIN_W'(ACC_LAT);
      else if (state == DRAIN)                       drain_cnt <= drain_cnt - DRAIN_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        in_vec[i] <= '0;
        res[i]    <= '0;
      end
      for (int i = 0; i < 16; i++) w_mat[i] <= '0;
      iter_reg <= ITER_W'(1);
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (data_wr && !busy) begin
        if (cmd_addr < 5'd4)            in_vec[cmd_addr[1:0]] <= cmd_wdata;
        else if (cmd_addr < ADDR_W_END) w_mat[4'(cmd_addr - 5'd4)] <= cmd_wdata;
        else                            iter_reg <= cmd_wdata[ITER_W-1:0];
      end
      if (clr_req) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (start_go) done <= 1'b0;
      // A dropped command flags err even if the same CTRL write also asks to clear it.
      if (busy && (data_wr || start_req)) err <= 1'b1;
      if (state == CAPTURE) begin
        done <= 1'b1;
        for (int i = 0; i < 4; i++) res[i] <= acc_out_flat[32*i +: 32];
      end
    end
  end

`ifdef NN_CTRL_IRQ_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (ctrl_wr) ie <= cmd_wdata[2];
      irq <= done & ie;
    end
  end
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  // Outside RUN the array sees zero operands so its accumulators hold.
  always_comb begin
    acc_in_flat = '0;
    acc_w_flat  = '0;
    if (state == RUN) begin
      for (int r = 0; r < 4; r++)  acc_in_flat[32*r +: 32] = in_vec[r];
      for (int i = 0; i < 16; i++) acc_w_flat[32*i +: 32]  = w_mat[i];
    end
  end

  always_comb begin
    rd_mux = '0;
    if (cmd_addr < 5'd4)                rd_mux = in_vec[cmd_addr[1:0]];
    else if (cmd_addr < ADDR_W_END)     rd_mux = w_mat[4'(cmd_addr - 5'd4)];
    else if (cmd_addr == ADDR_STATUS)   rd_mux = {28'b0, ie, err, done, busy};
    else if (cmd_addr == ADDR_ITER)     rd_mux = 32'(iter_reg);
    else if (cmd_addr[4:2] == 3'b110)   rd_mux = res[cmd_addr[1:0]];
  end

  // Read data is sampled on the accepting edge and presented one edge later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pend   <= 1'b0;
      rd_hold   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rd_pend   <= rd_en;
      rd_hold   <= rd_en ? rd_mux : '0;
      rsp_valid <= rd_pend;
      rsp_rdata <= rd_pend ? rd_hold : '0;
    end
  end

endmodule

// File: tb/tb_nn_accel_ctrl.sv
// Directed self-checking bench for nn_accel_ctrl with a behavioural diagonal MAC array (ACC_LAT = 1).
module tb_nn_accel_ctrl;

  logic         clock;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [4:0]   cmd_addr;
  logic [31:0]  cmd_wdata;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         busy;
  logic         irq;
  logic         acc_clear;
  logic [127:0] acc_in_flat;
  logic [511:0] acc_w_flat;
  logic [127:0] acc_out_flat;

  int errors = 0;
  int checks = 0;

  logic [31:0]  acc_reg [4];
  logic [31:0]  out_reg [4];
  logic [127:0] in_exp;
  logic [511:0] w_exp;

  nn_accel_ctrl #(.ACC_LAT(1), .ITER_W(8)) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy(busy),
    .irq(irq),
    .acc_clear(acc_clear),
    .acc_in_flat(acc_in_flat),
    .acc_w_flat(acc_w_flat),
    .acc_out_flat(acc_out_flat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Array model: lane r accumulates IN[r]*W[r][r]; one output register gives ACC_LAT = 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 4; r++) begin
        acc_reg[r] <= '0;
        out_reg[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 4; r++) begin
        if (acc_clear) acc_reg[r] <= '0;
        else acc_reg[r] <= acc_reg[r] + acc_in_flat[32*r +: 32] * acc_w_flat[160*r +: 32];
        out_reg[r] <= acc_reg[r];
      end
    end
  end

  assign acc_out_flat = {out_reg[3], out_reg[2], out_reg[1], out_reg[0]};

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [4:0] a, input logic [31:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s did not hold", tag);
    end
  endtask

  task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, a, d);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic readCheck(input string tag, input logic [4:0] a, input logic [31:0] expected);
    applyStimulus(1'b1, 1'b0, a, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput({tag, "_vld"}, rsp_valid, 1'b1);
    checkOutput(tag, rsp_rdata, expected);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    checkOutput("wait_idle", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_irq", irq, 1'b0);
    checkOutput("rst_clear", acc_clear, 1'b0);
    checkOutput("rst_in", acc_in_flat, 128'd0);
    checkOutput("rst_w", acc_w_flat, 512'd0);
    checkOutput("rst_rsp", rsp_valid, 1'b0);
    checkOutput("cmd_ready", cmd_ready, 1'b1);
    readCheck("rst_status", 5'd21, 32'd0);
    readCheck("rst_iter", 5'd22, 32'd1);
    readCheck("rst_w11", 5'd9, 32'd0);
    readCheck("rst_res0", 5'd24, 32'd0);

    // Load IN = [1,2,3,4], diagonal W = [5,6,7,8], ITER = 3
    writeReg(5'd0, 32'd1);
    writeReg(5'd1, 32'd2);
    writeReg(5'd2, 32'd3);
    writeReg(5'd3, 32'd4);
    writeReg(5'd4, 32'd5);
    writeReg(5'd9, 32'd6);
    writeReg(5'd14, 32'd7);
    writeReg(5'd19, 32'd8);
    writeReg(5'd22, 32'd3);
    readCheck("rd_in2", 5'd2, 32'd3);
    readCheck("rd_w22", 5'd14, 32'd7);
    readCheck("rd_iter", 5'd22, 32'd3);
    readCheck("rd_ctrl_wo", 5'd20, 32'd0);
    readCheck("rd_unmapped", 5'd23, 32'd0);

    in_exp = {32'd4, 32'd3, 32'd2, 32'd1};
    w_exp = '0;
    w_exp[31:0]    = 32'd5;
    w_exp[191:160] = 32'd6;
    w_exp[351:320] = 32'd7;
    w_exp[511:480] = 32'd8;

    // Cycle-exact run with ITER = 3: start accepted at edge t
    applyStimulus(1'b1, 1'b1, 5'd20, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("t0_busy", busy, 1'b1);
    checkOutput("t0_clear", acc_clear, 1'b1);
    checkOutput("t0_in_zero", acc_in_flat, 128'd0);
    tick();
    checkOutput("t1_clear", acc_clear, 1'b0);
    checkOutput("t1_in", acc_in_flat, in_exp);
    checkOutput("t1_w", acc_w_flat, w_exp);
    tick();
    checkOutput("t2_in", acc_in_flat, in_exp);
    tick();
    checkOutput("t3_in", acc_in_flat, in_exp);
    tick();
    checkOutput("t4_drain_in", acc_in_flat, 128'd0);
    checkOutput("t4_drain_w", acc_w_flat, 512'd0);
    checkOutput("t4_busy", busy, 1'b1);
    tick();
    checkOutput("t5_busy", busy, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'd21, 32'd0);
    tick();
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_no_rsp_yet", rsp_valid, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("cap_status_vld", rsp_valid, 1'b1);
    checkOutput("cap_status", rsp_rdata, 32'h1);
    tick();
    checkOutput("post_status_vld", rsp_valid, 1'b1);
    checkOutput("post_status", rsp_rdata, 32'h2);
    tick();
    checkOutput("rsp_drop", rsp_valid, 1'b0);
    readCheck("res0", 5'd24, 32'd15);
    readCheck("res1", 5'd25, 32'd36);
    readCheck("res2", 5'd26, 32'd63);
    readCheck("res3", 5'd27, 32'd96);

    // Writes and a start during RUN are dropped and flag err
    applyStimulus(1'b1, 1'b1, 5'd20, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd0, 32'd99);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd20, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    waitIdle();
    readCheck("err_status", 5'd21, 32'h6);
    readCheck("err_in0", 5'd0, 32'd1);
    readCheck("err_res0", 5'd24, 32'd15);
    readCheck("err_res3", 5'd27, 32'd96);
    writeReg(5'd20, 32'd2);
    readCheck("clr_status", 5'd21, 32'd0);

    // Writes to read-only addresses are ignored without err
    writeReg(5'd24, 32'd123);
    writeReg(5'd21, 32'd7);
    readCheck("ro_res0", 5'd24, 32'd15);
    readCheck("ro_status", 5'd21, 32'd0);

    // ITER = 0: straight from CLEAR to DRAIN, operands never driven
    writeReg(5'd22, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd20, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("z0_clear", acc_clear, 1'b1);
    tick();
    checkOutput("z1_in", acc_in_flat, 128'd0);
    checkOutput("z1_w", acc_w_flat, 512'd0);
    tick();
    checkOutput("z2_busy", busy, 1'b1);
    checkOutput("z2_in", acc_in_flat, 128'd0);
    tick();
    checkOutput("z3_busy", busy, 1'b0);
    readCheck("z_status", 5'd21, 32'h2);
    readCheck("z_res0", 5'd24, 32'd0);
    readCheck("z_res3", 5'd27, 32'd0);

    // Wrap-around: 0xFFFFFFFF * 2 accumulated twice
    for (int r = 0; r < 4; r++) begin
      writeReg(5'(r), 32'hFFFF_FFFF);
      writeReg(5'(4 + 5 * r), 32'd2);
    end
    writeReg(5'd22, 32'd2);
    writeReg(5'd20, 32'd1);
    waitIdle();
    readCheck("wrap_res0", 5'd24, 32'hFFFF_FFFC);
    readCheck("wrap_res1", 5'd25, 32'hFFFF_FFFC);
    readCheck("wrap_res3", 5'd27, 32'hFFFF_FFFC);

    // Reset two cycles into RUN
    applyStimulus(1'b1, 1'b1, 5'd20, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    checkOutput("pre_rst_in", acc_in_flat[31:0], 32'hFFFF_FFFF);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_clear", acc_clear, 1'b0);
    checkOutput("mid_rst_in", acc_in_flat, 128'd0);
    checkOutput("mid_rst_w", acc_w_flat, 512'd0);
    tick();
    reset = 1'b0;
    tick();
    readCheck("mr_status", 5'd21, 32'd0);
    readCheck("mr_iter", 5'd22, 32'd1);
    readCheck("mr_res0", 5'd24, 32'd0);
    readCheck("mr_in0", 5'd0, 32'd0);

    // Normal run after reset with the default ITER = 1
    writeReg(5'd0, 32'd1);
    writeReg(5'd1, 32'd2);
    writeReg(5'd2, 32'd3);
    writeReg(5'd3, 32'd4);
    writeReg(5'd4, 32'd5);
    writeReg(5'd9, 32'd6);
    writeReg(5'd14, 32'd7);
    writeReg(5'd19, 32'd8);
    writeReg(5'd20, 32'd1);
    waitIdle();
    readCheck("ar_res0", 5'd24, 32'd5);
    readCheck("ar_res1", 5'd25, 32'd12);
    readCheck("ar_res2", 5'd26, 32'd21);
    readCheck("ar_res3", 5'd27, 32'd32);

    // Completion interrupt
`ifdef NN_CTRL_IRQ_EN
    writeReg(5'd20, 32'd6);
    readCheck("ie_status", 5'd21, 32'h8);
    writeReg(5'd20, 32'd5);
    waitIdle();
    checkOutput("irq_at_done", irq, 1'b0);
    tick();
    checkOutput("irq_rise", irq, 1'b1);
    writeReg(5'd20, 32'd6);
    checkOutput("irq_hold", irq, 1'b1);
    tick();
    checkOutput("irq_fall", irq, 1'b0);
`else
    writeReg(5'd20, 32'd6);
    readCheck("ie_ignored", 5'd21, 32'd0);
    writeReg(5'd20, 32'd5);
    checkOutput("irq_busy", irq, 1'b0);
    waitIdle();
    checkOutput("irq_at_done", irq, 1'b0);
    tick();
    checkOutput("irq_after_done", irq, 1'b0);
    readCheck("noirq_status", 5'd21, 32'h2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
